// File: rtl/bist_vec_driver_misr.sv
// ---------------------------------------------------------------------------
// bist_vec_driver_misr
//
// Self-test harness stage wrapped around a combinational netlist. It drives
// a registered pseudo-random pattern into the netlist primary inputs. It holds
// each pattern for SETTLE cycles, then folds the netlist response into an 8-bit
// multiple-input signature register (MISR). After NUM_PATTERNS captures it
// raises done and reports pass when the signature equals golden_sig.
//
// Optional build macro: BIST_EXHAUSTIVE_EN
//   When defined, the pattern source is a binary up-counter that starts at
//   LFSR_SEED. A zero seed is kept as zero, and the counter wraps modulo
//   2^PI_W. When undefined, the pattern source is a Galois LFSR. That LFSR
//   uses LFSR_POLY, and a zero seed is replaced by 1. The MISR, the FSM and
//   the ports are identical in both builds.
//
// Ports:
//   clk         in   single clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle request to begin a run (ignored while busy)
//   golden_sig  in   [PO_W-1:0] expected signature, compared while done
//   po_vec      in   [PO_W-1:0] netlist outputs (combinational on pi_vec)
//   pi_vec      out  [PI_W-1:0] registered pattern driven to the netlist
//   busy        out  high while applying or capturing patterns
//   done        out  high once the run has finished
//   pass        out  high while done and signature == golden_sig
//   signature   out  [PO_W-1:0] MISR contents
//   pat_cnt     out  [PI_W:0]   number of patterns captured so far
// ---------------------------------------------------------------------------
module bist_vec_driver_misr #(
  parameter int              PI_W         = 14,
  parameter int              PO_W         = 8,
  parameter int              NUM_PATTERNS = 256,
  parameter int              SETTLE       = 1,
  parameter logic [PI_W-1:0] LFSR_POLY    = 14'h002B,
  parameter logic [PI_W-1:0] LFSR_SEED    = 14'h0001,
  parameter logic [PO_W-1:0] MISR_POLY    = 8'h1D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PO_W-1:0] golden_sig,
  input  logic [PO_W-1:0] po_vec,
  output logic [PI_W-1:0] pi_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [PO_W-1:0] signature,
  output logic [PI_W:0]   pat_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CW = PI_W + 1;
  localparam int SW = $clog2(SETTLE + 1);

  // The counter must be able to hold SETTLE itself, so SW is sized on SETTLE+1.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CW-1:0] NUM_PAT_C   = CW'(NUM_PATTERNS);

`ifdef BIST_EXHAUSTIVE_EN
  localparam logic [PI_W-1:0] SEED_EFF = LFSR_SEED;
`else
  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  localparam logic [PI_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;
`endif

  state_t          state, state_nx;
  logic [SW-1:0]   settle_cnt, settle_nx;
  logic [PI_W-1:0] pi_nx, pat_step;
  logic [PO_W-1:0] sig_nx, misr_step;
  logic [CW-1:0]   cnt_nx, cnt_inc;
  logic            busy_nx, done_nx;

  // Pattern generator step. Exhaustive builds count upward.
  // Default builds shift a Galois LFSR left, with feedback taken from the MSB.
  always_comb begin
`ifdef BIST_EXHAUSTIVE_EN
    pat_step = pi_vec + 1'b1;
`else
    pat_step = {pi_vec[PI_W-2:0], 1'b0} ^ (pi_vec[PI_W-1] ? LFSR_POLY : '0);
`endif
  end

  // MISR step: a Galois shift of the current signature, folded with the
  // netlist response that is present during the capture cycle.
  always_comb begin
    misr_step = {signature[PO_W-2:0], 1'b0} ^ (signature[PO_W-1] ? MISR_POLY : '0) ^ po_vec;
  end

  assign cnt_inc = pat_cnt + 1'b1;

  // Next-state and datapath decode. Everything holds unless the current state
  // says otherwise. A start seen in IDLE or DONE reloads the seed and clears
  // the signature, so a run never inherits state from the previous one.
  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    pi_nx     = pi_vec;
    sig_nx    = signature;
    cnt_nx    = pat_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          pi_nx     = SEED_EFF;
          sig_nx    = '0;
          cnt_nx    = '0;
          settle_nx = '0;
          state_nx  = APPLY;
        end
      end
      APPLY: begin
        settle_nx = settle_cnt + 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        sig_nx    = misr_step;
        pi_nx     = pat_step;
        cnt_nx    = cnt_inc;
        settle_nx = '0;
        state_nx  = (cnt_inc == NUM_PAT_C) ? DONE : APPLY;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx == APPLY) || (state_nx == CAPTURE);
    done_nx = (state_nx == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered status flags. busy and done are decoded from the
  // next state, so they line up exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      pi_vec     <= '0;
      signature  <= '0;
      pat_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      settle_cnt <= settle_nx;
      pi_vec     <= pi_nx;
      signature  <= sig_nx;
      pat_cnt    <= cnt_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // pass is combinational, so golden_sig may change while done is held.
  assign pass = done && (signature == golden_sig);

endmodule

// File: tb/tb_bist_vec_driver_misr.sv
// ---------------------------------------------------------------------------
// tb_bist_vec_driver_misr
//
// Scoreboard bench for bist_vec_driver_misr, using a 16-pattern, SETTLE=1
// configuration. The stimulus tasks push the expected pattern sequence and
// the expected end-of-run record into queues. Independent monitors pop them
// whenever the DUT presents a new pattern or raises done.
// ---------------------------------------------------------------------------
module tb_bist_vec_driver_misr;

  localparam int PI_W        = 14;
  localparam int PO_W        = 8;
  localparam int NPAT        = 16;
  localparam int SETTLE      = 1;
  localparam int RUN_CYCLES  = NPAT * (SETTLE + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PO_W-1:0] golden_sig = '0;
  logic [PO_W-1:0] po_vec = '0;
  logic [PI_W-1:0] pi_vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [PO_W-1:0] signature;
  logic [PI_W:0]   pat_cnt;

  typedef struct {
    logic [PO_W-1:0] sig;
    logic [PI_W:0]   cnt;
    logic            pass_exp;
    int              done_cyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [PI_W-1:0] exp_pi_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [PI_W-1:0] prev_pi = '0;
  logic            prev_done = 1'b0;

  bist_vec_driver_misr #(
    .PI_W(PI_W), .PO_W(PO_W), .NUM_PATTERNS(NPAT), .SETTLE(SETTLE),
    .LFSR_POLY(14'h002B), .LFSR_SEED(14'h0001), .MISR_POLY(8'h1D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden_sig(golden_sig),
    .po_vec(po_vec), .pi_vec(pi_vec), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_cnt(pat_cnt)
  );

  // Free-running clock and a cycle counter that advances on every rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One comparison. Any mismatch prints a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Hand-computed pattern k of a run that starts from seed 1.
  function automatic logic [PI_W-1:0] expPattern(input int k);
`ifdef BIST_EXHAUSTIVE_EN
    return PI_W'(k + 1);
`else
    if (k < 14)       return PI_W'(1) << k;
    else if (k == 14) return 14'h002B;
    else              return 14'h0056;
`endif
  endfunction

  // Pattern monitor. Every change of pi_vec while busy presents a new pattern.
  always @(negedge clk) begin
    if (busy && (pi_vec !== prev_pi)) begin
      if (exp_pi_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL pi_unexpected actual=0x%0h required=none", pi_vec);
      end else begin
        checkOutput("pi_vec", 32'(pi_vec), 32'(exp_pi_q.pop_front()));
      end
    end
    prev_pi <= pi_vec;
  end

  // End-of-run monitor. A rising edge of done pops one expected record.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_unexpected actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("signature", 32'(signature), 32'(e.sig));
        checkOutput("pat_cnt", 32'(pat_cnt), 32'(e.cnt));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("pass", 32'(pass), 32'(e.pass_exp));
        checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
    prev_done <= done;
  end

  // Pulse start for one cycle and push this run's expectations.
  task automatic applyStimulus(input logic [PO_W-1:0] po, input logic [PO_W-1:0] golden,
                               input logic [PO_W-1:0] exp_sig, input logic exp_pass);
    exp_t e;
    @(posedge clk);
    #1;
    po_vec = po;
    golden_sig = golden;
    start = 1'b1;
    for (int k = 0; k < NPAT; k++) exp_pi_q.push_back(expPattern(k));
    e.sig = exp_sig;
    e.cnt = (PI_W+1)'(NPAT);
    e.pass_exp = exp_pass;
    e.done_cyc = cyc + 1 + RUN_CYCLES;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait a bounded number of cycles for the scoreboard to drain.
  task automatic waitIdle();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=pending required=done");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pi_vec"}, 32'(pi_vec), 32'd0);
    checkOutput({tag, "_signature"}, 32'(signature), 32'd0);
    checkOutput({tag, "_pat_cnt"}, 32'(pat_cnt), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
  endtask

  // Main sequence. The MISR with po_vec held at 8'h01 over 16 captures
  // steps 01,03,07,0F,1F,3F,7F,FF,E2,D8,AC,44,89,0E,1D,3B, so the final
  // signature is 8'h3B.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    // Run A: zero response leaves the signature at zero, which matches golden 0.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1);
    waitIdle();

    // Run B: start in DONE restarts the run, and a stray start mid-run is ignored.
    applyStimulus(8'h01, 8'h3B, 8'h3B, 1'b1);
    checkOutput("restart_done", 32'(done), 32'd0);
    checkOutput("restart_signature", 32'(signature), 32'd0);
    checkOutput("restart_pi_vec", 32'(pi_vec), 32'd1);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    checkOutput("restart_pat_cnt", 32'(pat_cnt), 32'd0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();
    golden_sig = 8'h3C;
    #1;
    checkOutput("pass_golden_mismatch", 32'(pass), 32'd0);
    golden_sig = 8'h3B;
    #1;
    checkOutput("pass_golden_match", 32'(pass), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_signature", 32'(signature), 32'h3B);
    checkOutput("hold_pat_cnt", 32'(pat_cnt), 32'd16);
    checkOutput("hold_done", 32'(done), 32'd1);

    // Run C: an asynchronous reset mid-run aborts back to reset values.
    applyStimulus(8'h01, 8'h3B, 8'h3B, 1'b1);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("abort");
    exp_q.delete();
    exp_pi_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Run D: a full run from the seed after the abort. Golden 8'h3C does not match.
    applyStimulus(8'h01, 8'h3C, 8'h3B, 1'b0);
    waitIdle();
    checkOutput("pi_queue_drained", 32'(exp_pi_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
